// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed NUM_DIGITS-digit seven-segment controller with a sequential shift-add-3 BCD converter.
// Optional macro SSD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown, dashes never blanked).
module seven_seg_scan_ctrl #(
  parameter int DATA_W      = 8,
  parameter int NUM_DIGITS  = 3,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  localparam int          SCR_W = 4 * NUM_DIGITS;
  localparam int          CNT_W = $clog2(DATA_W + 1);
  localparam int          IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int          REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int          PAT_N = 1 << IDX_W;
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);
  localparam logic [6:0]  DASH  = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [SCR_W-1:0]  scr_q;
  logic [SCR_W-1:0]  scr_add3;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_next_q;
  logic              busy_q;
  logic              ovf_q;
  logic [SCR_W-1:0]  disp_q;

  logic [REF_W-1:0]      rcnt_q, rcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] show;
  logic [6:0]            pat [PAT_N];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign scr_add3[4*gi +: 4] = (scr_q[4*gi +: 4] >= 4'd5) ? scr_q[4*gi +: 4] + 4'd3
                                                              : scr_q[4*gi +: 4];
`ifdef SSD_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign show[gi] = 1'b1;
      end else begin : g_upper
        // A digit is lit only if it or some higher digit is non-zero.
        assign show[gi] = |disp_q[SCR_W-1:4*gi];
      end
`else
      assign show[gi] = 1'b1;
`endif
    end

    for (gi = 0; gi < PAT_N; gi++) begin : g_pat
      if (gi < NUM_DIGITS) begin : g_real
        assign pat[gi] = ovf_q ? DASH : (show[gi] ? dec7(disp_q[4*gi +: 4]) : 7'h7F);
      end else begin : g_pad
        assign pat[gi] = 7'h7F;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            shreg_q    <= data_in;
            scr_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            ovf_next_q <= (64'(data_in) >= LIMIT);
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shreg_q <= shreg_q << 1;
          scr_q   <= {scr_add3[SCR_W-2:0], shreg_q[DATA_W-1]};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          disp_q  <= scr_q;
          ovf_q   <= ovf_next_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Scan path: seg/an are computed from the next index so both move on the same edge.
  always_comb begin
    wrap   = (rcnt_q == REF_W'(REFRESH_DIV - 1));
    rcnt_d = wrap ? '0 : rcnt_q + REF_W'(1);
    idx_d  = idx_q;
    if (wrap) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    seg_d  = pat[idx_d];
    an_d   = ~(NUM_DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      seg_q  <= 7'h7F;
      an_q   <= '1;
    end else begin
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: a 3-digit and a 2-digit instance checked against an arithmetic display model.
module tb_seven_seg_scan_ctrl;

  localparam int DW  = 8;
  localparam int ND  = 3;
  localparam int ND2 = 2;
  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst;
  logic          load_a, load_b;
  logic [DW-1:0] din_a, din_b;
  logic          busy_a, ovf_a, busy_b, ovf_b;
  logic [6:0]    seg_a, seg_b;
  logic [ND-1:0] an_a;
  logic [ND2-1:0] an_b;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  seven_seg_scan_ctrl #(.DATA_W(DW), .NUM_DIGITS(ND), .REFRESH_DIV(DIV)) u_dut (
    .clk(clk), .arst(arst), .load(load_a), .data_in(din_a),
    .busy(busy_a), .ovf(ovf_a), .seg(seg_a), .an(an_a)
  );

  seven_seg_scan_ctrl #(.DATA_W(DW), .NUM_DIGITS(ND2), .REFRESH_DIV(DIV)) u_dut2 (
    .clk(clk), .arst(arst), .load(load_b), .data_in(din_b),
    .busy(busy_b), .ovf(ovf_b), .seg(seg_b), .an(an_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int value, input bit ov, input int idx);
    int p;
    if (ov) return 7'b0111111;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
`ifdef SSD_ZERO_BLANK_EN
    if (idx > 0 && value < p) return 7'h7F;
`endif
    return seg_tab[(value / p) % 10];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int sel, input int v);
    if (sel == 0) begin load_a = 1'b1; din_a = DW'(v); end
    else          begin load_b = 1'b1; din_b = DW'(v); end
    step();
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic busy_run(input int sel, output int n);
    n = 0;
    while (((sel == 0) ? busy_a : busy_b) && n < 100) begin
      n++;
      step();
    end
  endtask

  // One full scan rotation: exactly one anode low, segments match the model for that digit.
  task automatic scan_check(input int sel, input int value, input bit ov, input string tag);
    logic [7:0] a;
    logic [6:0] s;
    int nd, nz, idx;
    nd = (sel == 0) ? ND : ND2;
    for (int c = 0; c < nd * DIV; c++) begin
      a = (sel == 0) ? {5'h1F, an_a} : {6'h3F, an_b};
      s = (sel == 0) ? seg_a : seg_b;
      nz = 0;
      idx = 0;
      for (int i = 0; i < nd; i++) if (!a[i]) begin nz++; idx = i; end
      chk({tag, "_an_onehot"}, nz, 1);
      if (nz == 1) chk({tag, "_seg"}, s, exp_seg(value, ov, idx));
      step();
    end
  endtask

  task automatic convert(input int sel, input int v, input string tag);
    int n;
    bit ov;
    ov = (sel == 1) && (v >= 100);
    pulse(sel, v);
    busy_run(sel, n);
    chk({tag, "_busy_len"}, n, DW + 1);
    step();
    chk({tag, "_ovf"}, (sel == 0) ? ovf_a : ovf_b, ov);
    $display("load dut%0d value %0d busy %0d cycles ovf %0d", sel, v, n, ov);
    scan_check(sel, v, ov, tag);
  endtask

  initial begin
    int n;
    logic [ND-1:0]  ea;
    logic [ND2-1:0] eb;
    int v, sel;

    arst = 1'b1; load_a = 1'b0; load_b = 1'b0; din_a = '0; din_b = '0;
    step();
    step();
    chk("rst_busy", busy_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_seg", seg_a, 7'h7F);
    chk("rst_an", an_a, 3'b111);
    chk("rst_an2", an_b, 2'b11);
    arst = 1'b0;

    // Scan timing after release: index advances every DIV edges.
    for (int e = 1; e <= 3 * ND * DIV; e++) begin
      step();
      ea = ~(ND'(1) << ((e / DIV) % ND));
      eb = ~(ND2'(1) << ((e / DIV) % ND2));
      chk("scan_an", an_a, ea);
      chk("scan_an2", an_b, eb);
      chk("scan_seg", seg_a, exp_seg(0, 1'b0, (e / DIV) % ND));
    end

    convert(0, 255, "v255");

    // Load during conversion is dropped.
    pulse(0, 7);
    step();
    step();
    pulse(0, 42);
    busy_run(0, n);
    chk("drop_busy_len", n, DW - 2);
    step();
    $display("load dut0 value 7 with dropped 42, busy tail %0d", n);
    scan_check(0, 7, 1'b0, "drop");

    convert(1, 100, "ovf100");
    convert(1, 99, "v99");

    // Reset mid-conversion.
    pulse(0, 123);
    step();
    step();
    step();
    arst = 1'b1;
    step();
    arst = 1'b0;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ovf", ovf_a, 0);
    step();
    $display("load dut0 value 123 abandoned by reset");
    scan_check(0, 0, 1'b0, "midrst");
    for (int c = 0; c < 2 * DW; c++) begin
      chk("midrst_idle", busy_a, 0);
      step();
    end
    scan_check(0, 0, 1'b0, "midrst2");

    // Back-to-back loads DW+2 cycles apart.
    pulse(0, 10);
    busy_run(0, n);
    chk("b2b_first_len", n, DW + 1);
    pulse(0, 11);
    chk("b2b_accept", busy_a, 1);
    busy_run(0, n);
    chk("b2b_second_len", n, DW + 1);
    step();
    $display("load dut0 values 10,11 back-to-back");
    scan_check(0, 11, 1'b0, "b2b");

    for (int t = 0; t < 12; t++) begin
      v = $urandom_range(0, 255);
      sel = $urandom_range(0, 1);
      convert(sel, v, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
